dm_access_unit: RTL and testbench

Parametrised data-memory access unit between the MEM pipeline stage and a variable-latency data-memory port. Accepts one load/store request at a time over a valid/ready handshake. Checks natural alignment and generates byte enables and lane-shifted write data. Issues the access, waits for the memory response, then returns sign/zero-extended load data or an exception code as a one-cycle pulse. The pipeline stalls MEM while `req_ready` is low.

---
 rtl/dm_pkg.sv | 65 ++++++
 rtl/dm_lane_align.sv | 90 +++++++++
 rtl/dm_access_unit.sv | 153 +++++++++++++++
 tb/tb_dm_access_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared opcodes, exception codes, FSM encoding and decode helpers for the data-memory access unit.
package dm_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned EXC_W = 2;

  localparam logic [OP_W-1:0] OP_LW  = 4'd0;
  localparam logic [OP_W-1:0] OP_LH  = 4'd1;
  localparam logic [OP_W-1:0] OP_LHU = 4'd2;
  localparam logic [OP_W-1:0] OP_LB  = 4'd3;
  localparam logic [OP_W-1:0] OP_LBU = 4'd4;
  localparam logic [OP_W-1:0] OP_LWU = 4'd5;
  localparam logic [OP_W-1:0] OP_LD  = 4'd6;
  localparam logic [OP_W-1:0] OP_SW  = 4'd8;
  localparam logic [OP_W-1:0] OP_SH  = 4'd9;
  localparam logic [OP_W-1:0] OP_SB  = 4'd10;
  localparam logic [OP_W-1:0] OP_SD  = 4'd11;

  localparam logic [EXC_W-1:0] EXC_NONE = 2'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 2'd1;
  localparam logic [EXC_W-1:0] EXC_ADES = 2'd2;
  localparam logic [EXC_W-1:0] EXC_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Opcodes 0..6 are loads.
  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op <= OP_LD);
  endfunction

  // Opcodes 8..11 are stores.
  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op >= OP_SW) && (op <= OP_SD);
  endfunction

  // Loads whose result is sign-extended from the accessed field.
  function automatic logic is_signed_load(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

  // Access size of an opcode; illegal codes map to byte (never used).
  function automatic size_e access_size(input logic [OP_W-1:0] op);
    size_e sz;
    case (op)
      OP_LH, OP_LHU, OP_SH:        sz = SZ_HALF;
      OP_LW, OP_LWU, OP_SW:        sz = SZ_WORD;
      OP_LD, OP_SD:                sz = SZ_DWORD;
      default:                     sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: legality/alignment check, store lane shift and byte enables,
// load field extraction with sign/zero extension.
module dm_lane_align
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned LANES = DATA_W / 8,
  localparam int unsigned LSB_W = $clog2(LANES)
) (
  input  logic [OP_W-1:0]   chk_op,
  input  logic [2:0]        chk_addr_lo,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [EXC_W-1:0]  chk_exc_c,
  output logic [LANES-1:0]  st_be_c,
  output logic [DATA_W-1:0] st_wdata_c,
  input  logic [OP_W-1:0]   ld_op,
  input  logic [LSB_W-1:0]  ld_lane,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data_c
);

  localparam bit WIDE = (DATA_W == 64);
  localparam logic [DATA_W-1:0] M8  = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] M16 = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] M32 = DATA_W'(32'hFFFF_FFFF);

  logic [LSB_W-1:0]  st_lane;
  size_e             st_size;
  size_e             ld_size;
  logic              legal;
  logic              misaligned;
  logic              sgn;
  logic [DATA_W-1:0] field;

  assign st_lane = chk_addr_lo[LSB_W-1:0];
  assign st_size = access_size(chk_op);
  assign ld_size = access_size(ld_op);

  // Keep the low bits of v selected by m; fill the rest with s.
  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] v,
                                            input logic [DATA_W-1:0] m,
                                            input logic              s);
    return (v & m) | ({DATA_W{s}} & ~m);
  endfunction

  // Opcode legality for this width, then natural alignment.
  always_comb begin
    chk_exc_c  = EXC_NONE;
    legal      = is_load(chk_op) || is_store(chk_op);
    misaligned = 1'b0;
    if (!WIDE && ((chk_op == OP_LWU) || (chk_op == OP_LD) || (chk_op == OP_SD))) begin
      legal = 1'b0;
    end
    case (st_size)
      SZ_HALF:  misaligned = chk_addr_lo[0];
      SZ_WORD:  misaligned = |chk_addr_lo[1:0];
      SZ_DWORD: misaligned = |chk_addr_lo[2:0];
      default:  misaligned = 1'b0;
    endcase
    if (!legal) begin
      chk_exc_c = EXC_ILL;
    end else if (misaligned) begin
      chk_exc_c = is_load(chk_op) ? EXC_ADEL : EXC_ADES;
    end
  end

  // Store data moved onto its byte lanes, with matching byte enables.
  always_comb begin
    st_wdata_c = st_wdata << {st_lane, 3'b000};
    case (st_size)
      SZ_BYTE:  st_be_c = LANES'(1) << st_lane;
      SZ_HALF:  st_be_c = LANES'(3) << st_lane;
      SZ_WORD:  st_be_c = LANES'(4'hF) << st_lane;
      default:  st_be_c = '1;
    endcase
  end

  // Load field extraction and extension; a full-width access passes through.
  always_comb begin
    field = ld_rdata >> {ld_lane, 3'b000};
    sgn   = is_signed_load(ld_op);
    case (ld_size)
      SZ_BYTE: ld_data_c = ext(field, M8,  sgn & field[7]);
      SZ_HALF: ld_data_c = ext(field, M16, sgn & field[15]);
      SZ_WORD: ld_data_c = ext(field, M32, sgn & field[31]);
      default: ld_data_c = field;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: one request at a time, issue to memory, return extended data or exception.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned LANES = DATA_W / 8,
  localparam int unsigned LSB_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [EXC_W-1:0]  rsp_exc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [LANES-1:0]  mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [EXC_W-1:0]  rsp_exc_q, rsp_exc_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [LANES-1:0]  mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [LSB_W-1:0]  lane_q, lane_d;

  logic              accept_c;
  logic [EXC_W-1:0]  exc_c;
  logic [LANES-1:0]  be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ld_data_c;

  assign accept_c = req_valid && req_ready_q;

  dm_lane_align #(.DATA_W(DATA_W)) u_align (
    .chk_op      (req_op),
    .chk_addr_lo (req_addr[2:0]),
    .st_wdata    (req_wdata),
    .chk_exc_c   (exc_c),
    .st_be_c     (be_c),
    .st_wdata_c  (wdata_c),
    .ld_op       (op_q),
    .ld_lane     (lane_q),
    .ld_rdata    (mem_rsp_rdata),
    .ld_data_c   (ld_data_c)
  );

  // Next-state logic of the request/issue/wait/respond sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_c) state_d = (exc_c != EXC_NONE) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (mem_req_ready) state_d = is_store(op_q) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state; memory fields are zero outside ISSUE.
  always_comb begin
    op_d            = op_q;
    lane_d          = lane_q;
    req_ready_d     = (state_d == ST_IDLE);
    rsp_valid_d     = (state_d == ST_RESP);
    rsp_rdata_d     = '0;
    rsp_exc_d       = EXC_NONE;
    mem_req_valid_d = (state_d == ST_ISSUE);
    mem_addr_d      = '0;
    mem_we_d        = 1'b0;
    mem_be_d        = '0;
    mem_wdata_d     = '0;
    if (accept_c) begin
      op_d      = req_op;
      lane_d    = req_addr[LSB_W-1:0];
      rsp_exc_d = exc_c;
    end
    if (state_d == ST_ISSUE) begin
      if (state_q == ST_IDLE) begin
        mem_addr_d  = req_addr & ~ADDR_W'(LANES - 1);
        mem_we_d    = is_store(req_op);
        mem_be_d    = be_c;
        mem_wdata_d = wdata_c;
      end else begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
      end
    end
    if ((state_q == ST_WAIT) && mem_rsp_valid) begin
      rsp_rdata_d = ld_data_c;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_exc_q       <= EXC_NONE;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= '0;
      mem_wdata_q     <= '0;
      op_q            <= '0;
      lane_q          <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_exc_q       <= rsp_exc_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
      op_q            <= op_d;
      lane_q          <= lane_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_exc       = rsp_exc_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: 32-bit and 64-bit instances, directed table, reset corner, random vs model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  bit          sel64;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  logic        r32_ready, r32_rsp_valid, m32_valid, m32_we;
  logic [31:0] r32_rdata, m32_addr, m32_wdata;
  logic [1:0]  r32_exc;
  logic [3:0]  m32_be;
  logic        r64_ready, r64_rsp_valid, m64_valid, m64_we;
  logic [63:0] r64_rdata, m64_wdata;
  logic [31:0] m64_addr;
  logic [1:0]  r64_exc;
  logic [7:0]  m64_be;

  logic        o_req_ready, o_rsp_valid, o_mem_req_valid, o_mem_we;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [1:0]  o_rsp_exc;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_be;
  logic        any32, any64;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dm_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel64), .req_ready(r32_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(r32_rsp_valid), .rsp_rdata(r32_rdata), .rsp_exc(r32_exc),
    .mem_req_valid(m32_valid), .mem_req_ready(mem_req_ready & ~sel64),
    .mem_addr(m32_addr), .mem_we(m32_we), .mem_be(m32_be), .mem_wdata(m32_wdata),
    .mem_rsp_valid(mem_rsp_valid & ~sel64), .mem_rsp_rdata(mem_rsp_rdata[31:0])
  );

  dm_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel64), .req_ready(r64_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r64_rsp_valid), .rsp_rdata(r64_rdata), .rsp_exc(r64_exc),
    .mem_req_valid(m64_valid), .mem_req_ready(mem_req_ready & sel64),
    .mem_addr(m64_addr), .mem_we(m64_we), .mem_be(m64_be), .mem_wdata(m64_wdata),
    .mem_rsp_valid(mem_rsp_valid & sel64), .mem_rsp_rdata(mem_rsp_rdata)
  );

  assign o_req_ready     = sel64 ? r64_ready     : r32_ready;
  assign o_rsp_valid     = sel64 ? r64_rsp_valid : r32_rsp_valid;
  assign o_rsp_rdata     = sel64 ? r64_rdata     : {32'b0, r32_rdata};
  assign o_rsp_exc       = sel64 ? r64_exc       : r32_exc;
  assign o_mem_req_valid = sel64 ? m64_valid     : m32_valid;
  assign o_mem_addr      = sel64 ? m64_addr      : m32_addr;
  assign o_mem_we        = sel64 ? m64_we        : m32_we;
  assign o_mem_be        = sel64 ? m64_be        : {4'b0, m32_be};
  assign o_mem_wdata     = sel64 ? m64_wdata     : {32'b0, m32_wdata};
  assign any32 = |{r32_ready, r32_rsp_valid, r32_rdata, r32_exc, m32_valid, m32_addr, m32_we, m32_be, m32_wdata};
  assign any64 = |{r64_ready, r64_rsp_valid, r64_rdata, r64_exc, m64_valid, m64_addr, m64_we, m64_be, m64_wdata};

  typedef struct {
    logic [1:0]  exc;
    logic [31:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    bit          w64;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    int          rs;
    int          ws;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: access rules stated as byte counts and plain arithmetic.
  function automatic exp_t model(input bit w64, input logic [3:0] op, input logic [31:0] addr,
                                 input logic [63:0] wd, input logic [63:0] rd, input int rs, input int ws);
    exp_t r;
    int nb, lanes, lane;
    bit ld, st, sgn, legal;
    logic [63:0] dmask, fmask, field;
    r = '{2'd0, 32'd0, 8'd0, 1'b0, 64'd0, 64'd0, 1};
    nb = 0; ld = 0; st = 0; sgn = 0;
    case (op)
      0:  begin nb = 4; ld = 1; sgn = 1; end
      1:  begin nb = 2; ld = 1; sgn = 1; end
      2:  begin nb = 2; ld = 1; end
      3:  begin nb = 1; ld = 1; sgn = 1; end
      4:  begin nb = 1; ld = 1; end
      5:  begin nb = 4; ld = 1; end
      6:  begin nb = 8; ld = 1; end
      8:  begin nb = 4; st = 1; end
      9:  begin nb = 2; st = 1; end
      10: begin nb = 1; st = 1; end
      11: begin nb = 8; st = 1; end
      default: nb = 0;
    endcase
    legal = (ld || st) && (w64 || (nb != 8 && op != 5));
    lanes = w64 ? 8 : 4;
    dmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (!legal) begin
      r.exc = 2'd3;
    end else if ((addr % nb) != 0) begin
      r.exc = ld ? 2'd1 : 2'd2;
    end else begin
      lane    = int'(addr % lanes);
      r.addr  = addr - lane;
      r.be    = 8'(((1 << nb) - 1) << lane);
      r.we    = st;
      r.wdata = (wd << (8 * lane)) & dmask;
      if (ld) begin
        fmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        field = ((rd & dmask) >> (8 * lane)) & fmask;
        if (sgn && field[8*nb-1]) field = field | ~fmask;
        r.rdata = field & dmask;
        r.lat   = 3 + rs + ws;
      end else begin
        r.lat = 2 + rs;
      end
    end
    return r;
  endfunction

  // Drive one request, play the memory side with the given stalls, and check everything observed.
  task automatic run_txn(input string tag, input bit w64, input logic [3:0] op, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd, input int rs, input int ws,
                         input exp_t e);
    int rsp_c = 0, hs_c = 0, nreq = 0, nrsp = 0;
    bit seen_mem = 0, busy_err = 0, zero_err = 0, stab_err = 0, extra_err = 0, drv_rsp = 0;
    logic [31:0] c_addr = '0;
    logic [7:0]  c_be = '0;
    logic        c_we = 1'b0;
    logic [63:0] c_wdata = '0, c_rdata = '0;
    logic [1:0]  c_exc = '0;
    @(negedge clk);
    sel64 = w64;
    #1;
    chk({tag, " req_ready idle"}, 64'(o_req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_rdata = {$urandom, $urandom};
      if (rsp_c != 0 && c == rsp_c + 1) begin
        if (o_rsp_valid) nrsp++;
        chk({tag, " req_ready after"}, 64'(o_req_ready), 64'd1);
        break;
      end
      if (o_req_ready) busy_err = 1;
      if (o_rsp_valid) begin
        nrsp++; rsp_c = c; c_rdata = o_rsp_rdata; c_exc = o_rsp_exc;
      end else if (o_rsp_rdata != 0 || o_rsp_exc != 0) begin
        zero_err = 1;
      end
      if (o_mem_req_valid) begin
        if (hs_c != 0) extra_err = 1;
        else begin
          if (!seen_mem) begin
            c_addr = o_mem_addr; c_be = o_mem_be; c_we = o_mem_we; c_wdata = o_mem_wdata;
          end else if (o_mem_addr != c_addr || o_mem_be != c_be || o_mem_we != c_we || o_mem_wdata != c_wdata) begin
            stab_err = 1;
          end
          seen_mem = 1;
          if (nreq >= rs) begin mem_req_ready = 1'b1; hs_c = c; end
          nreq++;
        end
      end else if (o_mem_addr != 0 || o_mem_be != 0 || o_mem_we != 0 || o_mem_wdata != 0) begin
        zero_err = 1;
      end
      if (hs_c != 0 && c > hs_c && !drv_rsp && !e.we && (c - hs_c - 1) == ws) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rd; drv_rsp = 1;
      end
    end
    chk({tag, " rsp pulses"}, 64'(nrsp), 64'd1);
    chk({tag, " latency"}, 64'(rsp_c), 64'(e.lat));
    chk({tag, " rsp_exc"}, 64'(c_exc), 64'(e.exc));
    chk({tag, " rsp_rdata"}, c_rdata, e.rdata);
    chk({tag, " busy/zero/extra"}, {61'd0, busy_err, zero_err, extra_err}, 64'd0);
    chk({tag, " mem issued"}, 64'(seen_mem), 64'(e.exc == 2'd0));
    if (e.exc == 2'd0) begin
      chk({tag, " mem_addr"}, 64'(c_addr), 64'(e.addr));
      chk({tag, " mem_be"}, 64'(c_be), 64'(e.be));
      chk({tag, " mem_we"}, 64'(c_we), 64'(e.we));
      chk({tag, " mem_wdata"}, c_wdata, e.wdata);
      chk({tag, " mem stable"}, 64'(stab_err), 64'd0);
    end
  endtask

  vec_t tab[16];
  bit   err;

  initial begin
    tab[0]  = '{0, 4'd10, 32'h1003, 64'hAB, 64'h0, 0, 0, '{2'd0, 32'h1000, 8'h08, 1'b1, 64'hAB00_0000, 64'h0, 2}};
    tab[1]  = '{0, 4'd1, 32'h2002, 64'h0, 64'h8001_1234, 0, 3, '{2'd0, 32'h2000, 8'h0C, 1'b0, 64'h0, 64'hFFFF_8001, 6}};
    tab[2]  = '{0, 4'd2, 32'h2002, 64'h0, 64'h8001_1234, 0, 3, '{2'd0, 32'h2000, 8'h0C, 1'b0, 64'h0, 64'h0000_8001, 6}};
    tab[3]  = '{0, 4'd0, 32'h0006, 64'h0, 64'h0, 0, 0, '{2'd1, 32'h0, 8'h0, 1'b0, 64'h0, 64'h0, 1}};
    tab[4]  = '{0, 4'd9, 32'h0001, 64'h1234, 64'h0, 0, 0, '{2'd2, 32'h0, 8'h0, 1'b0, 64'h0, 64'h0, 1}};
    tab[5]  = '{0, 4'd6, 32'h0000, 64'h0, 64'h0, 0, 0, '{2'd3, 32'h0, 8'h0, 1'b0, 64'h0, 64'h0, 1}};
    tab[6]  = '{1, 4'd5, 32'h0104, 64'h0, 64'h8000_0000_0000_0000, 0, 0,
                '{2'd0, 32'h0100, 8'hF0, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 3}};
    tab[7]  = '{0, 4'd8, 32'h0040, 64'h1234_5678, 64'h0, 5, 0, '{2'd0, 32'h0040, 8'h0F, 1'b1, 64'h1234_5678, 64'h0, 7}};
    tab[8]  = '{0, 4'd3, 32'h3001, 64'h0, 64'h0000_F300, 0, 0, '{2'd0, 32'h3000, 8'h02, 1'b0, 64'h0, 64'hFFFF_FFF3, 3}};
    tab[9]  = '{0, 4'd7, 32'h0000, 64'h0, 64'h0, 0, 0, '{2'd3, 32'h0, 8'h0, 1'b0, 64'h0, 64'h0, 1}};
    tab[10] = '{1, 4'd13, 32'h0008, 64'h0, 64'h0, 0, 0, '{2'd3, 32'h0, 8'h0, 1'b0, 64'h0, 64'h0, 1}};
    tab[11] = '{1, 4'd0, 32'h0008, 64'h0, 64'h0000_0000_8000_0000, 0, 0,
                '{2'd0, 32'h0008, 8'h0F, 1'b0, 64'h0, 64'hFFFF_FFFF_8000_0000, 3}};
    tab[12] = '{1, 4'd11, 32'h0010, 64'h1122_3344_5566_7788, 64'h0, 0, 0,
                '{2'd0, 32'h0010, 8'hFF, 1'b1, 64'h1122_3344_5566_7788, 64'h0, 2}};
    tab[13] = '{1, 4'd10, 32'h0007, 64'hCD, 64'h0, 0, 0, '{2'd0, 32'h0000, 8'h80, 1'b1, 64'hCD00_0000_0000_0000, 64'h0, 2}};
    tab[14] = '{1, 4'd6, 32'h0004, 64'h0, 64'h0, 0, 0, '{2'd1, 32'h0, 8'h0, 1'b0, 64'h0, 64'h0, 1}};
    tab[15] = '{1, 4'd8, 32'h0004, 64'hDEAD_BEEF, 64'h0, 1, 0, '{2'd0, 32'h0000, 8'hF0, 1'b1, 64'hDEAD_BEEF_0000_0000, 64'h0, 3}};

    reset = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs dut32", 64'(any32), 64'd0);
    chk("reset outputs dut64", 64'(any64), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready after reset dut32", 64'(r32_ready), 64'd1);
    chk("req_ready after reset dut64", 64'(r64_ready), 64'd1);

    // Stray memory response while idle must not produce a completion.
    err = 0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h5555_5555_5555_5555;
    repeat (3) begin
      @(negedge clk);
      if (r32_rsp_valid || r32_rdata != 0) err = 1;
    end
    mem_rsp_valid = 1'b0;
    chk("idle stray mem_rsp ignored", 64'(err), 64'd0);

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("vec%0d", i), tab[i].w64, tab[i].op, tab[i].addr, tab[i].wd, tab[i].rd,
              tab[i].rs, tab[i].ws, tab[i].e);
    end

    // Reset while a load waits for memory; the late response must be dropped.
    @(negedge clk);
    sel64 = 1'b0;
    req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h10; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midreset issue seen", 64'(m32_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("midreset in wait", 64'(m32_valid | r32_ready | r32_rsp_valid), 64'd0);
    reset = 1'b1;
    #1;
    chk("midreset outputs zero", 64'(any32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h0000_0000_CAFE_F00D;
    err = 0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    repeat (3) begin
      if (r32_rsp_valid || r32_rdata != 0 || r32_exc != 0 || m32_valid) err = 1;
      @(negedge clk);
    end
    chk("midreset late rsp ignored", 64'(err), 64'd0);
    run_txn("post-reset LW", 1'b0, 4'd0, 32'h10, 64'h0, 64'h0000_0000_CAFE_F00D, 0, 1,
            model(1'b0, 4'd0, 32'h10, 64'h0, 64'h0000_0000_CAFE_F00D, 0, 1));

    // Random requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      bit          w;
      logic [3:0]  op;
      logic [31:0] a;
      logic [63:0] wd, rd;
      int          rs, ws;
      w  = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a  = ($urandom & 32'h0000_FFF8) | ($urandom_range(0, 1) ? 32'd0 : 32'($urandom_range(0, 7)));
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      rs = $urandom_range(0, 2);
      ws = $urandom_range(0, 2);
      run_txn($sformatf("rnd%0d", i), w, op, a, wd, rd, rs, ws, model(w, op, a, wd, rd, rs, ws));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
